// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM state type for the memory responder.
package wisc_mem_pkg;

    localparam int LINE_WORDS  = 8;
    localparam int LATENCY_DEF = 4;
    localparam int IDX_W       = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a requester and mem_responder.
interface mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              enable;
    logic              wr;
    logic              burst;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_in;
    logic [15:0]       data_out;
    logic              data_valid;
    logic [2:0]        word_idx;
    logic              busy;

    modport master (
        output enable, wr, burst, addr, data_in,
        input  data_out, data_valid, word_idx, busy
    );

    modport slave (
        input  enable, wr, burst, addr, data_in,
        output data_out, data_valid, word_idx, busy
    );
endinterface

// File: rtl/mem_lat_pipe.sv
// Fixed-latency delay line carrying {valid, word index, data} for read responses.
module mem_lat_pipe #(
    parameter int LATENCY = 4,
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_p0,
    input  logic [IDX_W-1:0]  idx_p0,
    input  logic [DATA_W-1:0] data_p0,
    output logic              out_vld,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_pn  [LATENCY];
    logic [IDX_W-1:0]  idx_pn  [LATENCY];
    logic [DATA_W-1:0] data_pn [LATENCY];

    // Shift every stage forward each cycle; reset wipes in-flight responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_pn[i]  <= 1'b0;
                idx_pn[i]  <= '0;
                data_pn[i] <= '0;
            end
        end else begin
            vld_pn[0]  <= vld_p0;
            idx_pn[0]  <= idx_p0;
            data_pn[0] <= data_p0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pn[i]  <= vld_pn[i-1];
                idx_pn[i]  <= idx_pn[i-1];
                data_pn[i] <= data_pn[i-1];
            end
        end
    end

    assign out_vld  = vld_pn[LATENCY-1];
    assign out_idx  = idx_pn[LATENCY-1];
    assign out_data = data_pn[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory with pipelined single reads and cache-line burst reads.
module mem_responder #(
    parameter int LATENCY    = wisc_mem_pkg::LATENCY_DEF,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = wisc_mem_pkg::LINE_WORDS
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);
    import wisc_mem_pkg::*;

    localparam int WA_W   = ADDR_W - 1;
    localparam int LIDX_W = $clog2(LINE_WORDS);
    localparam int DATA_W = 16;

    logic [DATA_W-1:0] mem [0:(1<<WA_W)-1];

    state_t                   state, state_nxt;
    logic [LIDX_W-1:0]        cnt, cnt_nxt;
    logic [WA_W-LIDX_W-1:0]   line_q, line_nxt;

    logic [WA_W-1:0]          waddr_req;
    logic [WA_W-1:0]          rd_waddr;
    logic                     vld_p0;
    logic [LIDX_W-1:0]        idx_p0;
    logic [DATA_W-1:0]        data_p0;
    logic [LIDX_W-1:0]        out_idx;
    logic                     unused_addr0;

    assign waddr_req    = bus.addr[ADDR_W-1:1];
    assign unused_addr0 = bus.addr[0];

    // Next-state logic plus the read-issue address generator; word 0 of a burst goes out in the accept cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        line_nxt  = line_q;
        vld_p0    = 1'b0;
        idx_p0    = '0;
        rd_waddr  = waddr_req;
        case (state)
            IDLE: begin
                if (bus.enable && !bus.wr) begin
                    vld_p0 = 1'b1;
                    if (bus.burst) begin
                        line_nxt  = waddr_req[WA_W-1:LIDX_W];
                        rd_waddr  = {waddr_req[WA_W-1:LIDX_W], {LIDX_W{1'b0}}};
                        cnt_nxt   = LIDX_W'(1);
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                vld_p0   = 1'b1;
                idx_p0   = cnt;
                rd_waddr = {line_q, cnt};
                cnt_nxt  = cnt + LIDX_W'(1);
                if (cnt == LIDX_W'(LINE_WORDS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM, burst counter and line register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            line_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            line_q <= line_nxt;
        end
    end

    // Writes land only when idle; requests during a burst are dropped.
    always_ff @(posedge clk) begin
        if (rst_n && bus.enable && bus.wr && state == IDLE) begin
            mem[waddr_req] <= bus.data_in;
        end
    end

    assign data_p0 = mem[rd_waddr];

    mem_lat_pipe #(
        .LATENCY (LATENCY),
        .DATA_W  (DATA_W),
        .IDX_W   (LIDX_W)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .vld_p0   (vld_p0),
        .idx_p0   (idx_p0),
        .data_p0  (data_p0),
        .out_vld  (bus.data_valid),
        .out_idx  (out_idx),
        .out_data (bus.data_out)
    );

    assign bus.word_idx = 3'(out_idx);
    assign bus.busy     = (state == BURST);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver predicts responses, monitor checks them.
module tb_mem_responder;
    import wisc_mem_pkg::*;

    localparam int LAT = 4;
    localparam int AW  = 16;
    localparam int NW  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst_q = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(AW)) bus();

    mem_responder #(
        .LATENCY    (LAT),
        .ADDR_W     (AW),
        .LINE_WORDS (NW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
        logic [2:0]  idx;
    } exp_t;

    exp_t        expq[$];
    exp_t        cur;
    logic [15:0] ref_mem [0:127];
    int          cyc     = 0;
    int          busy_lo = -1;
    int          busy_hi = -2;
    int          n_chk   = 0;
    int          n_fail  = 0;
    bit          mon_on  = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // One bench cycle: drive inputs just after the edge and update the reference model.
    task automatic step(input bit en, input bit wr, input bit bst, input int a,
                        input logic [15:0] d, input bit rstn);
        int   w;
        bit   busy_now;
        exp_t keep[$];
        @(posedge clk);
        #1;
        rst_n        = rstn;
        bus.enable   = en;
        bus.wr       = wr;
        bus.burst    = bst;
        bus.addr     = 16'(a);
        bus.data_in  = d;
        busy_now     = (cyc >= busy_lo) && (cyc <= busy_hi);
        w            = (a >> 1) & 127;
        if (!rstn) begin
            foreach (expq[i]) if (expq[i].due <= cyc) keep.push_back(expq[i]);
            expq = keep;
            if (busy_hi > cyc) busy_hi = cyc;
        end else if (en && !busy_now) begin
            if (wr) begin
                ref_mem[w] = d;
            end else if (!bst) begin
                expq.push_back('{cyc + LAT, ref_mem[w], 3'd0});
            end else begin
                for (int i = 0; i < NW; i++)
                    expq.push_back('{cyc + LAT + i, ref_mem[(w & ~(NW - 1)) + i], 3'(i)});
                busy_lo = cyc + 1;
                busy_hi = cyc + NW - 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 16'h0, 1);
    endtask

    task automatic rd(input int a);
        step(1, 0, 0, a, 16'h0, 1);
    endtask

    task automatic wrt(input int a, input logic [15:0] d);
        step(1, 1, 0, a, d, 1);
    endtask

    // Monitor: compare every cycle's outputs against the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", 32'(bus.busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (!rst_q) begin
                check("reset_data_out", 32'(bus.data_out), 32'h0);
                check("reset_word_idx", 32'(bus.word_idx), 32'h0);
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                cur = expq.pop_front();
                check("data_valid", 32'(bus.data_valid), 32'h1);
                check("data_out", 32'(bus.data_out), 32'(cur.data));
                check("word_idx", 32'(bus.word_idx), 32'(cur.idx));
            end else begin
                check("no_response", 32'(bus.data_valid), 32'h0);
            end
        end
    end

    initial begin
        logic [15:0] v;
        int          r;
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.burst   = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        for (int w = 0; w < 128; w++) begin
            v          = 16'($urandom);
            ref_mem[w] = v;
            dut.mem[w] = v;
        end
        ref_mem[8] = 16'hBEEF;
        dut.mem[8] = 16'hBEEF;
        for (int i = 0; i < NW; i++) begin
            ref_mem[16'h20 + i] = 16'hA000 + 16'(i);
            dut.mem[16'h20 + i] = 16'hA000 + 16'(i);
        end

        step(0, 0, 0, 0, 16'h0, 0);
        mon_on = 1'b1;
        step(0, 0, 0, 0, 16'h0, 0);
        idle(2);

        // single read latency
        rd(16'h0010);
        idle(6);

        // write then read, later write must not disturb the in-flight read
        wrt(16'h0020, 16'h1234);
        rd(16'h0020);
        wrt(16'h0020, 16'h5678);
        idle(6);

        // burst from unaligned address, write dropped while busy, then verify line intact
        step(1, 0, 1, 16'h0046, 16'h0, 1);
        idle(2);
        wrt(16'h0040, 16'hFFFF);
        idle(12);
        rd(16'h0040);
        idle(6);

        // back-to-back in-order single reads
        rd(16'h0000);
        rd(16'h0002);
        rd(16'h0004);
        idle(6);

        // reset in the middle of a burst discards it
        step(1, 0, 1, 16'h0080, 16'h0, 1);
        idle(2);
        step(0, 0, 0, 0, 16'h0, 0);
        idle(12);

        // requests every cycle after a burst: the one in the cycle busy falls is taken
        step(1, 0, 1, 16'h00A2, 16'h0, 1);
        for (int i = 0; i < NW + 1; i++) rd(16'h0010 + 2 * i);
        idle(8);

        // wr with burst acts as a single write
        step(1, 1, 1, 16'h0060, 16'hC0DE, 1);
        rd(16'h0062);
        rd(16'h0060);
        idle(6);

        // randomized traffic within the preloaded window
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 255),
                 16'($urandom), r != 0);
        end
        idle(LAT + NW + 4);

        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request accept to data_valid.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter LINE_WORDS, default 8, words per burst (cache-line fill).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  request valid this cycle.
REQ-007 wr  in  1  1 = write, 0 = read; qualified by enable.
REQ-008 burst  in  1  with enable & !wr: line-fill read of LINE_WORDS words.
REQ-009 addr  in  ADDR_W  byte address; bit 0 ignored (16-bit words).
REQ-010 data_in  in  16  write data.
REQ-011 data_out  out  16  read data, meaningful only while data_valid.
REQ-012 data_valid  out  1  data_out carries a read response this cycle.
REQ-013 word_idx  out  3  position of the returned word within its burst; 0 for single reads.
REQ-014 busy  out  1  burst issue in progress; new requests ignored.

Function
REQ-015 Storage: 2^(ADDR_W-1) x 16-bit words, indexed by addr[ADDR_W-1:1].
REQ-016 Write: enable & wr & !busy updates the word at the accepting edge; no response is generated.
REQ-017 Single read: enable & !wr & !burst & !busy captures mem[addr] at the accepting edge; data_valid is asserted exactly LATENCY cycles later for one cycle, with word_idx = 0.
REQ-018 Reads are fully pipelined: one accepted read per cycle, returned in order with no bubbles.
REQ-019 Read data snapshots at accept: a write accepted in a later cycle does not alter an in-flight read; a read accepted the cycle after a write returns the new value.
REQ-020 FSM states IDLE and BURST; reset state IDLE.
REQ-021 IDLE -> BURST on enable & !wr & burst: base = addr with bits [3:0] cleared; word 0 is issued in the accept cycle.
REQ-022 In BURST, one internal read per cycle for words 1..LINE_WORDS-1 at base + 2*i.
REQ-023 BURST -> IDLE after word LINE_WORDS-1 is issued; busy is high for exactly LINE_WORDS-1 cycles after the accept cycle.
REQ-024 Burst responses appear on LINE_WORDS consecutive cycles, word_idx 0..7, the first LATENCY cycles after the accept.
REQ-025 Address arithmetic within a burst stays inside the aligned line; no carry out of bit 3.
REQ-026 Requests of any kind while busy are dropped: no write, no response.
REQ-027 A new request is accepted in the cycle busy falls; its responses follow the last burst word back-to-back.
REQ-028 enable with wr=1 and burst=1 is treated as a single write; burst is ignored.

Reset
REQ-029 When rst_n=0 at an edge: FSM -> IDLE, all pipeline valid bits cleared, data_valid=0, busy=0, word_idx=0, data_out=0.
REQ-030 Reset during a burst or with reads in flight discards them; no data_valid after reset release until a new read completes LATENCY cycles after accept.
REQ-031 Memory contents are not cleared by reset; the bench preloads them through the array named mem.

Structure
REQ-032 Package wisc_mem_pkg holds LINE_WORDS, the default LATENCY, and the FSM state enum.
REQ-033 Sub-module mem_lat_pipe: a LATENCY-stage shift register of {valid, word_idx, data} with synchronous clear.
REQ-034 The top module contains only the storage array mem, the FSM with its burst counter, and the address generator.

Verification
REQ-035 Preload mem[0x0010>>1]=0xBEEF; read 0x0010 in cycle 0 -> data_valid=1, data_out=0xBEEF in cycle 4 only.
REQ-036 Write 0x1234 to 0x0020 in cycle 0, read 0x0020 in cycle 1 -> 0x1234 in cycle 5; write 0x5678 in cycle 2 -> no change to that response.
REQ-037 Burst read at addr 0x0046 with mem words i=0..7 of line 0x0040 preloaded as 0xA000+i -> cycles 4..11 return 0xA000..0xA007 with word_idx 0..7; busy high in cycles 1..7.
REQ-038 Write 0xFFFF to 0x0040 in cycle 3 during that burst -> ignored; mem[0x20] is unchanged and no extra response occurs.
REQ-039 Reads to 0x0000, 0x0002 and 0x0004 in cycles 0-2 -> in-order responses in cycles 4-6.
REQ-040 Reset asserted in cycle 3 of a burst -> data_valid=0 and busy=0 from cycle 4 on, with no stale responses.
